// File: rtl/codemem_pkg.sv
// Shared types for the banked code memory: bank ownership states and the
// per-word parity width (non-zero only when CODEMEM_PARITY_EN is defined).
package codemem_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2,
    ACTIVE  = 2'd3
  } bank_state_e;

`ifdef CODEMEM_PARITY_EN
  localparam int PARITY_W = 1;
`else
  localparam int PARITY_W = 0;
`endif

endpackage

// File: rtl/codemem_banked_bank.sv
// One code bank: simple dual-port RAM, synchronous write, registered read.
// The read register only updates on re_i, so the last fetched word is held.
module codemem_bank
  import codemem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WORD_WIDTH-1:0] rdata_o
);

  logic [WORD_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [WORD_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/codemem_banked.sv
// Ring of NUM_BANKS code banks: loader fills/commits one bank while the CPU
// fetches from another. Optional per-word even parity via CODEMEM_PARITY_EN.
module codemem_banked
  import codemem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_BANKS      = 2,
  parameter int BANK_IDX_WIDTH = $clog2(NUM_BANKS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_en,
  input  logic                      wr_commit,
  output logic                      wr_ready,
  output logic [BANK_IDX_WIDTH-1:0] wr_bank,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_data_vld,
  input  logic                      rd_release,
  output logic                      rd_valid,
  output logic [BANK_IDX_WIDTH-1:0] rd_bank
`ifdef CODEMEM_PARITY_EN
  ,
  output logic                      rd_parity_err
`endif
);

  localparam int WORD_W = DATA_WIDTH + PARITY_W;

  bank_state_e                state_q [NUM_BANKS];
  bank_state_e                state_d [NUM_BANKS];
  logic [BANK_IDX_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [BANK_IDX_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BANK_IDX_WIDTH-1:0]  sel_q;
  logic                       vld_q;
  logic                       seen_q;
  logic                       wr_acc, cm_acc, rd_acc, rel_acc;
  logic [WORD_W-1:0]          wr_word;
  logic [WORD_W-1:0]          rd_word;
  logic [WORD_W-1:0]          bank_rdata [NUM_BANKS];

  assign wr_ready = (state_q[wr_ptr_q] == EMPTY) || (state_q[wr_ptr_q] == LOADING);
  assign rd_valid = (state_q[rd_ptr_q] == ACTIVE);
  assign wr_acc   = wr_en      & wr_ready;
  assign cm_acc   = wr_commit  & wr_ready;
  assign rd_acc   = rd_en      & rd_valid;
  assign rel_acc  = rd_release & rd_valid;

  // Load and fetch pointers never address the same bank with overlapping
  // states, so the write/commit and promote/release updates cannot collide.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) state_d[wr_ptr_q] = LOADING;
    if (cm_acc) begin
      state_d[wr_ptr_q] = READY;
      wr_ptr_d          = wr_ptr_q + BANK_IDX_WIDTH'(1);
    end
    if (state_q[rd_ptr_q] == READY) state_d[rd_ptr_q] = ACTIVE;
    if (rel_acc) begin
      state_d[rd_ptr_q] = EMPTY;
      rd_ptr_d          = rd_ptr_q + BANK_IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) state_q[i] <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sel_q    <= '0;
      vld_q    <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= rd_acc;
      if (rd_acc) begin
        sel_q  <= rd_ptr_q;
        seen_q <= 1'b1;
      end
    end
  end

`ifdef CODEMEM_PARITY_EN
  assign wr_word = {^wr_data, wr_data};
`else
  assign wr_word = wr_data;
`endif

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    codemem_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORD_WIDTH (WORD_W)
    ) u_bank (
      .clk     (clk),
      .we_i    (wr_acc && (wr_ptr_q == BANK_IDX_WIDTH'(g))),
      .waddr_i (wr_addr),
      .wdata_i (wr_word),
      .re_i    (rd_acc && (rd_ptr_q == BANK_IDX_WIDTH'(g))),
      .raddr_i (rd_addr),
      .rdata_o (bank_rdata[g])
    );
  end

  // Bank read registers carry no reset; seen_q forces zero until the first fetch.
  assign rd_word     = bank_rdata[sel_q];
  assign rd_data     = seen_q ? rd_word[DATA_WIDTH-1:0] : '0;
  assign rd_data_vld = vld_q;
  assign wr_bank     = wr_ptr_q;
  assign rd_bank     = rd_ptr_q;

`ifdef CODEMEM_PARITY_EN
  assign rd_parity_err = vld_q & (^rd_word);
`endif

endmodule

// File: tb/tb_codemem_banked.sv
// Bench for codemem_banked: directed handover scenarios followed by random
// traffic, checked against a timestamp-based ownership model.
module tb_codemem_banked;

  localparam int NB = 2;
  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          wr_commit = 1'b0;
  logic          wr_ready;
  logic          wr_bank;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_data_vld;
  logic          rd_release = 1'b0;
  logic          rd_valid;
  logic          rd_bank;
`ifdef CODEMEM_PARITY_EN
  logic          rd_parity_err;
`endif

  always #5 clk = ~clk;

  codemem_banked #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_BANKS  (NB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .wr_commit   (wr_commit),
    .wr_ready    (wr_ready),
    .wr_bank     (wr_bank),
    .rd_addr     (rd_addr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld),
    .rd_release  (rd_release),
    .rd_valid    (rd_valid),
    .rd_bank     (rd_bank)
`ifdef CODEMEM_PARITY_EN
    ,
    .rd_parity_err (rd_parity_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: programs are a FIFO of commit timestamps (clock edges);
  // a program becomes fetchable one edge after both its commit and the
  // release of its predecessor have happened.
  logic [DW-1:0] mm [NB][2**AW];
  bit            mp [NB][2**AW];
  bit            wv [NB][2**AW];
  int            q[$];
  int            k = 0;
  int            last_rel = -1;
  int            commits = 0;
  int            releases = 0;
  logic [DW-1:0] exp_data = '0;
  bit            exp_known = 1'b1;
  bit            exp_vld = 1'b0;
  bit            exp_perr = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_rd_valid();
    int avail;
    if (q.size() == 0) return 1'b0;
    avail = ((q[0] > last_rel) ? q[0] : last_rel) + 1;
    return avail <= k;
  endfunction

  task automatic model_reset();
    q.delete();
    k = 0;
    last_rel = -1;
    commits = 0;
    releases = 0;
    exp_data = '0;
    exp_known = 1'b1;
    exp_vld = 1'b0;
    exp_perr = 1'b0;
  endtask

  task automatic check_outputs();
    chk("wr_ready", DW'(wr_ready), DW'(q.size() < NB));
    chk("wr_bank", DW'(wr_bank), DW'(commits % NB));
    chk("rd_valid", DW'(rd_valid), DW'(m_rd_valid()));
    chk("rd_bank", DW'(rd_bank), DW'(releases % NB));
    chk("rd_data_vld", DW'(rd_data_vld), DW'(exp_vld));
    if (exp_known) chk("rd_data", rd_data, exp_data);
`ifdef CODEMEM_PARITY_EN
    if (exp_known) chk("rd_parity_err", DW'(rd_parity_err), DW'(exp_perr));
`endif
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic cyc(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input bit wc, input bit re, input logic [AW-1:0] ra, input bit rr);
    bit p_wr, p_rv;
    int wb, rb;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_commit = wc;
    rd_en = re; rd_addr = ra; rd_release = rr;
    p_wr = (q.size() < NB);
    p_rv = m_rd_valid();
    wb = commits % NB;
    rb = releases % NB;
    @(posedge clk);
    k++;
    exp_vld = re && p_rv;
    exp_perr = 1'b0;
    if (exp_vld) begin
      exp_known = wv[rb][ra];
      exp_data  = mm[rb][ra];
      exp_perr  = ((^mm[rb][ra]) != mp[rb][ra]);
    end
    if (we && p_wr) begin
      mm[wb][wa] = wd;
      mp[wb][wa] = ^wd;
      wv[wb][wa] = 1'b1;
    end
    if (wc && p_wr) begin
      q.push_back(k);
      commits++;
    end
    if (rr && p_rv) begin
      void'(q.pop_front());
      last_rel = k;
      releases++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    model_reset();

    // Single load, commit, promotion and fetch
    cyc(1'b1, 10'd3, 64'hA5, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("commit_wr_bank", DW'(wr_bank), 64'd1);
    chk("valid_commit_p1", DW'(rd_valid), 64'd0);
    idle();
    chk("valid_commit_p2", DW'(rd_valid), 64'd1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 10'd3, 1'b0);
    chk("read_a5", rd_data, 64'hA5);
    chk("read_a5_vld", DW'(rd_data_vld), 64'd1);
    idle();
    chk("vld_pulse", DW'(rd_data_vld), 64'd0);

    // Full ring: loader blocked until the CPU releases
    cyc(1'b1, 10'd7, 64'h7777, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("full_wr_ready", DW'(wr_ready), 64'd0);
    cyc(1'b1, 10'd3, 64'hDEAD, 1'b1, 1'b0, '0, 1'b0);
    chk("full_ignored_bank", DW'(wr_bank), 64'd0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 10'd3, 1'b0);
    chk("full_no_overwrite", rd_data, 64'hA5);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("rel_wr_ready", DW'(wr_ready), 64'd1);
    chk("rel_rd_bank", DW'(rd_bank), 64'd1);
    chk("rel_valid_drop", DW'(rd_valid), 64'd0);
    idle();
    chk("rel_valid_rerise", DW'(rd_valid), 64'd1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 10'd7, 1'b0);
    chk("read_bank1", rd_data, 64'h7777);

    // Commit and release on the same edge
    cyc(1'b1, 10'd2, 64'h2222, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
    chk("both_rd_bank", DW'(rd_bank), 64'd0);
    chk("both_wr_bank", DW'(wr_bank), 64'd1);
    chk("both_valid_drop", DW'(rd_valid), 64'd0);
    idle();
    chk("both_valid_rise", DW'(rd_valid), 64'd1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 10'd2, 1'b0);
    chk("both_read", rd_data, 64'h2222);

    // Fetch while no bank is active is ignored
    cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 10'd2, 1'b0);
    chk("idle_read_vld", DW'(rd_data_vld), 64'd0);
    chk("idle_read_hold", rd_data, 64'h2222);

    // Bring bank 0 to ACTIVE, start loading bank 1, then reset asynchronously
    cyc(1'b1, 10'd1, 64'h1010, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle();
    cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 10'd5, 64'h5555_0000_0000_5A5A, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle();
    cyc(1'b1, 10'd6, 64'h6666, 1'b0, 1'b1, 10'd5, 1'b0);
    chk("pre_reset_read", rd_data, 64'h5555_0000_0000_5A5A);
    #2;
    rst_n = 1'b0;
    wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    chk("post_reset_valid", DW'(rd_valid), 64'd0);

    // Commit with no writes; RAM contents survive reset
    cyc(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle();
    chk("empty_commit_valid", DW'(rd_valid), 64'd1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 10'd5, 1'b0);
    chk("ram_kept", rd_data, 64'h5555_0000_0000_5A5A);

`ifdef CODEMEM_PARITY_EN
    dut.g_bank[0].u_bank.mem_q[5][3] = ~dut.g_bank[0].u_bank.mem_q[5][3];
    mm[0][5][3] = ~mm[0][5][3];
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 10'd5, 1'b0);
    chk("parity_flip", DW'(rd_parity_err), 64'd1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 10'd3, 1'b0);
    chk("parity_clean", DW'(rd_parity_err), 64'd0);
`endif

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 1) != 0, AW'($urandom_range(0, 7)), {$urandom, $urandom},
          $urandom_range(0, 5) == 0, $urandom_range(0, 1) != 0, AW'($urandom_range(0, 7)),
          $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
